dma_loopback_ctrl: RTL and testbench

AFU-side controller that drives the peripheral side of the team's abstract DMA interface: on a host-triggered go, it issues a DMA read and a DMA write of the same size, then moves every cache line from the read stream to the write stream through a one-entry holding register. It sits between the MMIO register block (which supplies addresses, size and go, and polls done) and the DMA engine (which hides CCI-P). Full throughput is one line per cycle when the read stream is non-empty and the write stream is not full.

---
 rtl/dma_loopback_ctrl.sv | 139 +++++++++++++
 tb/tb_dma_loopback_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_loopback_ctrl.sv
`default_nettype none
// dma_loopback_ctrl: copies size cache lines from the DMA read stream to the DMA write
// stream through a one-entry holding register. Revision 1.0
module dma_loopback_ctrl #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 42,
  parameter int SIZE_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE_WIDTH-1:0] words_copied,
  output logic                  dma_rd_go,
  output logic                  dma_wr_go,
  output logic [ADDR_WIDTH-1:0] dma_rd_addr,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic [SIZE_WIDTH-1:0] dma_rd_size,
  output logic [SIZE_WIDTH-1:0] dma_wr_size,
  output logic                  dma_rd_en,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  input  logic                  dma_empty,
  input  logic                  dma_rd_done,
  output logic                  dma_wr_en,
  output logic [DATA_WIDTH-1:0] dma_wr_data,
  input  logic                  dma_full,
  input  logic                  dma_wr_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [SIZE_WIDTH-1:0] SIZE_ONE = SIZE_WIDTH'(1);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [SIZE_WIDTH-1:0] rd_count;
  logic [SIZE_WIDTH-1:0] size_q;
  logic                  in_xfer;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  accept_go;
  logic                  last_push;

  assign in_xfer   = (state == S_XFER);
  assign wr_fire   = in_xfer && hold_valid && !dma_full;
  // A pop may refill the holding register in the same cycle it is being drained.
  assign rd_fire   = in_xfer && !dma_empty && (rd_count < size_q) && (!hold_valid || wr_fire);
  assign accept_go = go && ((state == S_IDLE) || (state == S_DONE));
  assign last_push = wr_fire && ((words_copied + SIZE_ONE) == size_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (go) state_nxt = (size == '0) ? S_DONE : S_START;
      S_START:        state_nxt = S_XFER;
      S_XFER:         if (last_push) state_nxt = S_DRAIN;
      S_DRAIN:        if (dma_rd_done && dma_wr_done) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    dma_rd_go = 1'b0;
    dma_wr_go = 1'b0;
    dma_rd_en = 1'b0;
    dma_wr_en = 1'b0;
    case (state)
      S_START: begin
        busy      = 1'b1;
        dma_rd_go = 1'b1;
        dma_wr_go = 1'b1;
      end
      S_XFER: begin
        busy      = 1'b1;
        dma_rd_en = rd_fire;
        dma_wr_en = wr_fire;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dma_rd_addr  <= '0;
      dma_wr_addr  <= '0;
      size_q       <= '0;
      words_copied <= '0;
      rd_count     <= '0;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
    end else if (accept_go) begin
      dma_rd_addr  <= rd_addr;
      dma_wr_addr  <= wr_addr;
      size_q       <= size;
      words_copied <= '0;
      rd_count     <= '0;
      hold_valid   <= 1'b0;
    end else begin
      if (rd_fire) begin
        hold_data  <= dma_rd_data;
        hold_valid <= 1'b1;
        rd_count   <= rd_count + SIZE_ONE;
      end else if (wr_fire) begin
        hold_valid <= 1'b0;
      end
      if (wr_fire) begin
        words_copied <= words_copied + SIZE_ONE;
      end
    end
  end

  assign dma_rd_size = size_q;
  assign dma_wr_size = size_q;
  assign dma_wr_data = hold_data;

endmodule
`default_nettype wire

// File: tb/tb_dma_loopback_ctrl.sv
`default_nettype none
// tb_dma_loopback_ctrl: directed transfers checked every cycle against a line-count
// level model of the copy engine, plus literal expectations per scenario.
module tb_dma_loopback_ctrl;
  localparam int DW = 512;
  localparam int AW = 42;
  localparam int SW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [SW-1:0] size = '0;
  logic          busy, done, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en;
  logic [SW-1:0] words_copied, dma_rd_size, dma_wr_size;
  logic [AW-1:0] dma_rd_addr, dma_wr_addr;
  logic [DW-1:0] dma_wr_data;
  logic [DW-1:0] dma_rd_data = '0;
  logic          dma_empty = 1'b1;
  logic          dma_rd_done = 1'b0;
  logic          dma_full = 1'b0;
  logic          dma_wr_done = 1'b0;

  always #5 clk = ~clk;

  dma_loopback_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .rd_addr(rd_addr), .wr_addr(wr_addr), .size(size),
    .busy(busy), .done(done), .words_copied(words_copied),
    .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
    .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
    .dma_rd_size(dma_rd_size), .dma_wr_size(dma_wr_size),
    .dma_rd_en(dma_rd_en), .dma_rd_data(dma_rd_data), .dma_empty(dma_empty),
    .dma_rd_done(dma_rd_done), .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data),
    .dma_full(dma_full), .dma_wr_done(dma_wr_done)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Line idx of a transfer whose source address carries the given tag.
  function automatic logic [DW-1:0] gen(input logic [31:0] tag, input int idx);
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++)
      v[i*32 +: 32] = tag * 32'h9E3779B1 + 32'(idx) * 32'h01000193 + 32'(i);
    return v;
  endfunction

  // Transfer-level model: phase flags, lines popped/pushed, holding occupancy.
  bit            chk_on = 0;
  bit            m_busy = 0, m_done = 0, m_go = 0, m_xfer = 0, m_drain = 0, m_occ = 0;
  int            m_popped = 0, m_copied = 0, m_size = 0;
  logic [AW-1:0] m_rd_addr = '0, m_wr_addr = '0;
  int            cyc = 0, go_cyc = 0;
  int            n_rdgo = 0, n_wrgo = 0, n_rden = 0, n_wren = 0, first_rden = 0, last_rden = 0;
  bit            full_toggle = 0, empty_rand = 0, hold_wr_done = 0;

  always @(negedge clk) begin
    logic e_wr, e_rd;
    e_wr = m_xfer && m_occ && !dma_full;
    e_rd = m_xfer && !dma_empty && (m_popped < m_size) && (!m_occ || e_wr);
    if (chk_on) begin
      check("busy", DW'(busy), DW'(m_busy));
      check("done", DW'(done), DW'(m_done));
      check("words_copied", DW'(words_copied), DW'(m_copied));
      check("dma_rd_go", DW'(dma_rd_go), DW'(m_go));
      check("dma_wr_go", DW'(dma_wr_go), DW'(m_go));
      check("dma_rd_en", DW'(dma_rd_en), DW'(e_rd));
      check("dma_wr_en", DW'(dma_wr_en), DW'(e_wr));
      check("dma_rd_addr", DW'(dma_rd_addr), DW'(m_rd_addr));
      check("dma_wr_addr", DW'(dma_wr_addr), DW'(m_wr_addr));
      check("dma_rd_size", DW'(dma_rd_size), DW'(m_size));
      check("dma_wr_size", DW'(dma_wr_size), DW'(m_size));
      if (e_wr) check("dma_wr_data", dma_wr_data, gen(m_rd_addr[31:0], m_copied));
    end
    if (dma_rd_go) n_rdgo++;
    if (dma_wr_go) n_wrgo++;
    if (dma_wr_en) n_wren++;
    if (dma_rd_en) begin
      if (n_rden == 0) first_rden = cyc;
      last_rden = cyc;
      n_rden++;
    end
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_go = 0; m_xfer = 0; m_drain = 0; m_occ = 0;
      m_popped = 0; m_copied = 0; m_size = 0; m_rd_addr = '0; m_wr_addr = '0;
    end else if (!m_busy && go) begin
      m_rd_addr = rd_addr; m_wr_addr = wr_addr; m_size = int'(size);
      m_popped = 0; m_copied = 0; m_occ = 0; go_cyc = cyc;
      if (size == '0) begin
        m_done = 1; m_busy = 0;
      end else begin
        m_done = 0; m_busy = 1; m_go = 1;
      end
    end else if (m_go) begin
      m_go = 0; m_xfer = 1;
    end else if (m_xfer) begin
      if (e_rd) m_popped++;
      if (e_wr) m_copied++;
      m_occ = e_rd ? 1'b1 : (e_wr ? 1'b0 : m_occ);
      if (m_copied == m_size) begin
        m_xfer = 0; m_drain = 1;
      end
    end else if (m_drain && dma_rd_done && dma_wr_done) begin
      m_drain = 0; m_busy = 0; m_done = 1;
    end
    cyc++;
  end

  // DMA engine stand-in: FWFT source stream, optional back-pressure, done levels.
  always @(posedge clk) begin
    #1;
    dma_rd_data = (m_popped < m_size) ? gen(m_rd_addr[31:0], m_popped) : '0;
    dma_empty   = (m_popped >= m_size) || (empty_rand && ($urandom_range(0, 1) == 1));
    dma_full    = full_toggle ? ~dma_full : 1'b0;
    dma_rd_done = m_busy && !m_go && (m_popped == m_size);
    dma_wr_done = m_busy && !m_go && (m_copied == m_size) && !hold_wr_done;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [AW-1:0] ra, input logic [AW-1:0] wa, input int sz);
    rd_addr = ra; wr_addr = wa; size = SW'(sz); go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (!done && i < budget) begin
      step();
      i++;
    end
    check(name, DW'(done), DW'(1));
  endtask

  task automatic clear_stats();
    n_rdgo = 0; n_wrgo = 0; n_rden = 0; n_wren = 0;
  endtask

  initial begin
    int i;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    chk_on = 1;
    check("reset_busy", DW'(busy), DW'(0));
    check("reset_done", DW'(done), DW'(0));
    check("reset_words", DW'(words_copied), DW'(0));

    // Unstalled size=4 copy
    clear_stats();
    start(42'h100, 42'h200, 4);
    wait_done("t1_done", 100);
    check("t1_words", DW'(words_copied), DW'(4));
    check("t1_rdgo_count", DW'(n_rdgo), DW'(1));
    check("t1_wrgo_count", DW'(n_wrgo), DW'(1));
    check("t1_rden_count", DW'(n_rden), DW'(4));
    check("t1_wren_count", DW'(n_wren), DW'(4));
    check("t1_rden_back_to_back", DW'(last_rden - first_rden), DW'(3));
    check("t1_first_rden_latency", DW'(first_rden - go_cyc), DW'(2));
    check("t1_last_wr_data", dma_wr_data, gen(32'h100, 3));

    // size=8 with toggling full and random empty
    clear_stats();
    full_toggle = 1; empty_rand = 1;
    start(42'h3_0000_0040, 42'h3_0000_0080, 8);
    wait_done("t2_done", 400);
    full_toggle = 0; empty_rand = 0;
    check("t2_words", DW'(words_copied), DW'(8));
    check("t2_wren_count", DW'(n_wren), DW'(8));
    check("t2_rden_count", DW'(n_rden), DW'(8));

    // size=0 completes immediately without DMA activity
    step(2);
    clear_stats();
    start(42'h500, 42'h600, 0);
    check("t3_done_next_cycle", DW'(done), DW'(1));
    check("t3_busy", DW'(busy), DW'(0));
    step(3);
    check("t3_no_go", DW'(n_rdgo + n_wrgo), DW'(0));
    check("t3_no_en", DW'(n_rden + n_wren), DW'(0));

    // go during XFER is ignored
    start(42'h1_2345, 42'h2_3456, 16);
    step(4);
    rd_addr = 42'h7_7777; wr_addr = 42'h8_8888; size = SW'(5); go = 1'b1;
    step();
    go = 1'b0;
    wait_done("t4_done", 200);
    check("t4_rd_addr", DW'(dma_rd_addr), DW'(42'h1_2345));
    check("t4_wr_addr", DW'(dma_wr_addr), DW'(42'h2_3456));
    check("t4_size", DW'(dma_rd_size), DW'(16));
    check("t4_words", DW'(words_copied), DW'(16));

    // Reset after 3 of 10 lines, then a fresh size=2 copy
    start(42'h900, 42'hA00, 10);
    i = 0;
    while (words_copied != SW'(3) && i < 50) begin
      step();
      i++;
    end
    check("t5_reached_3", DW'(words_copied), DW'(3));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_rst_busy", DW'(busy), DW'(0));
    check("t5_rst_done", DW'(done), DW'(0));
    check("t5_rst_words", DW'(words_copied), DW'(0));
    check("t5_rst_rd_addr", DW'(dma_rd_addr), DW'(0));
    check("t5_rst_wr_data", dma_wr_data, '0);
    clear_stats();
    step(3);
    check("t5_no_pulses_after_reset", DW'(n_rdgo + n_wrgo + n_rden + n_wren), DW'(0));
    start(42'hB00, 42'hC00, 2);
    wait_done("t5_done", 100);
    check("t5_words", DW'(words_copied), DW'(2));

    // Back-to-back go from DONE, holding wr_done to stretch the drain
    hold_wr_done = 1;
    start(42'hD00, 42'hE00, 3);
    check("t6_done_cleared", DW'(done), DW'(0));
    check("t6_busy", DW'(busy), DW'(1));
    step(12);
    check("t6_drain_waits", DW'(done), DW'(0));
    check("t6_words_before_done", DW'(words_copied), DW'(3));
    hold_wr_done = 0;
    wait_done("t6_done", 20);
    check("t6_wr_addr", DW'(dma_wr_addr), DW'(42'hE00));
    check("t6_last_wr_data", dma_wr_data, gen(32'hD00, 2));

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
